// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 8-bit async SRAM between CPU and VGA with a starve limit.
// Define VGA_PREFETCH_EN to add the one-entry VGA next-address prefetch buffer.
module sram_arbiter #(
   parameter int RD_WAIT_CYCLES   = 1,
   parameter int WR_PULSE_CYCLES  = 2,
   parameter int VGA_STARVE_LIMIT = 4
) (
   input  logic        clkMem,
   input  logic        sysRst,
   input  logic        cpuReq,
   input  logic        cpuWe,
   input  logic [15:0] cpuAddr,
   input  logic [7:0]  cpuWData,
   output logic        cpuAck,
   output logic [7:0]  cpuRData,
   input  logic        vgaReq,
   input  logic [15:0] vgaAddr,
   output logic        vgaAck,
   output logic [7:0]  vgaRData,
   output logic [15:0] memAddr,
   inout  wire  [7:0]  memData,
   output logic        memReN,
   output logic        memWeN,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE, RD, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD
   } state_t;

   localparam logic [2:0] RD_WAIT    = 3'(RD_WAIT_CYCLES);
   localparam logic [2:0] WR_WAIT    = 3'(WR_PULSE_CYCLES - 1);
   localparam logic [3:0] STARVE_MAX = 4'(VGA_STARVE_LIMIT);
   localparam logic [1:0] SRC_CPU    = 2'd0;
   localparam logic [1:0] SRC_VGA    = 2'd1;
`ifdef VGA_PREFETCH_EN
   localparam logic [1:0] SRC_PF     = 2'd2;
`endif

   state_t      state;
   logic [2:0]  wait_cnt;
   logic [3:0]  starve;
   logic [1:0]  src;
   logic        drive;
   logic [7:0]  wdata;
   logic        pick_vga;
   logic        pick_cpu;

`ifdef VGA_PREFETCH_EN
   logic        pf_valid;
   logic        pf_pending;
   logic [15:0] pf_tag;
   logic [7:0]  pf_data;
   logic [15:0] last_vga;
   logic        pf_hit;

   assign pf_hit = pf_valid && (vgaAddr == pf_tag);
`endif

   assign pick_vga = vgaReq && (!cpuReq || starve == STARVE_MAX);
   assign pick_cpu = cpuReq && !pick_vga;
   assign memData  = drive ? wdata : 8'hzz;
   assign busy     = (state != IDLE);

   always_ff @(posedge clkMem or posedge sysRst) begin
      if (sysRst) begin
         state    <= IDLE;
         wait_cnt <= '0;
         starve   <= '0;
         src      <= SRC_CPU;
         drive    <= 1'b0;
         wdata    <= '0;
         memAddr  <= '0;
         memReN   <= 1'b1;
         memWeN   <= 1'b1;
         cpuAck   <= 1'b0;
         vgaAck   <= 1'b0;
         cpuRData <= '0;
         vgaRData <= '0;
`ifdef VGA_PREFETCH_EN
         pf_valid   <= 1'b0;
         pf_pending <= 1'b0;
         pf_tag     <= '0;
         pf_data    <= '0;
         last_vga   <= '0;
`endif
      end else begin
         cpuAck <= 1'b0;
         vgaAck <= 1'b0;
         unique case (state)
            IDLE: begin
               if (!vgaReq) starve <= '0;
               if (pick_cpu) begin
                  if (vgaReq && starve != STARVE_MAX)
                     starve <= starve + 4'd1;
                  memAddr <= cpuAddr;
                  src     <= SRC_CPU;
                  if (cpuWe) begin
                     state <= WR_SETUP;
                     drive <= 1'b1;
                     wdata <= cpuWData;
`ifdef VGA_PREFETCH_EN
                     if (cpuAddr == pf_tag) pf_valid <= 1'b0;
`endif
                  end else begin
                     state    <= RD;
                     memReN   <= 1'b0;
                     wait_cnt <= RD_WAIT;
                  end
               end else if (pick_vga) begin
                  starve <= '0;
                  src    <= SRC_VGA;
`ifdef VGA_PREFETCH_EN
                  last_vga <= vgaAddr;
                  if (pf_hit) begin
                     // Served from the buffer: no strobe activity.
                     state      <= RD_DONE;
                     vgaAck     <= 1'b1;
                     vgaRData   <= pf_data;
                     pf_valid   <= 1'b0;
                     pf_pending <= 1'b1;
                  end else begin
                     state    <= RD;
                     memAddr  <= vgaAddr;
                     memReN   <= 1'b0;
                     wait_cnt <= RD_WAIT;
                  end
`else
                  state    <= RD;
                  memAddr  <= vgaAddr;
                  memReN   <= 1'b0;
                  wait_cnt <= RD_WAIT;
`endif
               end
`ifdef VGA_PREFETCH_EN
               else if (pf_pending) begin
                  state      <= RD;
                  src        <= SRC_PF;
                  memAddr    <= last_vga + 16'd1;
                  memReN     <= 1'b0;
                  wait_cnt   <= RD_WAIT;
                  pf_pending <= 1'b0;
               end
`endif
            end
            RD: begin
               if (wait_cnt == 3'd0) begin
                  memReN <= 1'b1;
                  state  <= RD_DONE;
                  if (src == SRC_CPU) begin
                     cpuAck   <= 1'b1;
                     cpuRData <= memData;
                  end else if (src == SRC_VGA) begin
                     vgaAck   <= 1'b1;
                     vgaRData <= memData;
`ifdef VGA_PREFETCH_EN
                     pf_pending <= 1'b1;
`endif
                  end
`ifdef VGA_PREFETCH_EN
                  else begin
                     pf_valid <= 1'b1;
                     pf_tag   <= memAddr;
                     pf_data  <= memData;
                  end
`endif
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            RD_DONE: state <= IDLE;
            WR_SETUP: begin
               memWeN   <= 1'b0;
               wait_cnt <= WR_WAIT;
               state    <= WR_PULSE;
            end
            WR_PULSE: begin
               if (wait_cnt == 3'd0) begin
                  memWeN <= 1'b1;
                  cpuAck <= 1'b1;
                  state  <= WR_HOLD;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            WR_HOLD: begin
               drive <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of strobe timing, arbitration and reset.
// Prefetch checks compile in when VGA_PREFETCH_EN is defined.
module tb_sram_arbiter;

   logic        clkMem = 1'b0;
   logic        sysRst;
   logic        cpuReq, cpuWe;
   logic [15:0] cpuAddr;
   logic [7:0]  cpuWData;
   logic        cpuAck;
   logic [7:0]  cpuRData;
   logic        vgaReq;
   logic [15:0] vgaAddr;
   logic        vgaAck;
   logic [7:0]  vgaRData;
   logic [15:0] memAddr;
   wire  [7:0]  memData;
   logic        memReN, memWeN, busy;

   logic [7:0]  sram [0:65535];
   int          total = 0;
   int          bad = 0;

   sram_arbiter dut (
      .clkMem(clkMem), .sysRst(sysRst),
      .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr),
      .cpuWData(cpuWData), .cpuAck(cpuAck), .cpuRData(cpuRData),
      .vgaReq(vgaReq), .vgaAddr(vgaAddr), .vgaAck(vgaAck),
      .vgaRData(vgaRData), .memAddr(memAddr), .memData(memData),
      .memReN(memReN), .memWeN(memWeN), .busy(busy)
   );

   always #5 clkMem = ~clkMem;

   // Simple async SRAM: drives on output enable, latches while write enable low.
   assign memData = memReN ? 8'hzz : sram[memAddr];
   always @(posedge clkMem)
      if (!memWeN) sram[memAddr] = memData;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clkMem);
   endtask

   task automatic txn(input bit vga, input bit we, input logic [15:0] a,
                      input logic [7:0] d, output int ack_cyc,
                      output int re_lo, output int we_lo, output int drv);
      ack_cyc = -1; re_lo = 0; we_lo = 0; drv = 0;
      if (vga) begin
         vgaReq = 1'b1; vgaAddr = a;
      end else begin
         cpuReq = 1'b1; cpuWe = we; cpuAddr = a; cpuWData = d;
      end
      for (int c = 1; c <= 40 && ack_cyc < 0; c++) begin
         @(posedge clkMem);
         @(negedge clkMem);
         if (!memReN) re_lo++;
         if (!memWeN) we_lo++;
         if (memReN && memData === d) drv++;
         if (vga ? vgaAck : cpuAck) ack_cyc = c;
      end
      cpuReq = 1'b0;
      vgaReq = 1'b0;
   endtask

   initial begin
      int    ack, re, wl, dv, n, seen;
      string exp_seq;
      byte   seq [10];

      sysRst = 1'b1;
      cpuReq = 0; cpuWe = 0; cpuAddr = '0; cpuWData = '0;
      vgaReq = 0; vgaAddr = '0;
      for (int i = 0; i < 65536; i++) sram[i] = 8'h00;
      sram[16'h1234] = 8'hA5;
      sram[16'h0777] = 8'h6E;
      sram[16'hFFFF] = 8'hC3;
      sram[16'h2000] = 8'h11;
      sram[16'h2001] = 8'h22;

      idle(2);
      chk("rst_ren", memReN, 1);
      chk("rst_wen", memWeN, 1);
      chk("rst_addr", memAddr, 0);
      chk("rst_data_z", 32'(memData === 8'hzz), 1);
      chk("rst_acks", {cpuAck, vgaAck}, 0);
      chk("rst_rdata", {cpuRData, vgaRData}, 0);
      chk("rst_busy", busy, 0);
      sysRst = 1'b0;
      idle(2);

      txn(0, 0, 16'h1234, 8'h00, ack, re, wl, dv);
      chk("rd_ack_cyc", ack, 3);
      chk("rd_ren_low", re, 2);
      chk("rd_wen_low", wl, 0);
      chk("rd_data", cpuRData, 8'hA5);
      chk("rd_addr", memAddr, 16'h1234);
      idle(1);
      chk("rd_ack_pulse", cpuAck, 0);
      chk("rd_busy_after", busy, 0);

      txn(0, 1, 16'hBFFF, 8'h3C, ack, re, wl, dv);
      chk("wr_ack_cyc", ack, 4);
      chk("wr_wen_low", wl, 2);
      chk("wr_ren_low", re, 0);
      chk("wr_drive_cyc", dv, 4);
      idle(1);
      chk("wr_data_z", 32'(memData === 8'hzz), 1);
      chk("wr_ack_pulse", cpuAck, 0);
      chk("wr_sram", sram[16'hBFFF], 8'h3C);

      txn(1, 0, 16'h0777, 8'h00, ack, re, wl, dv);
      chk("vga_ack_cyc", ack, 3);
      chk("vga_ren_low", re, 2);
      chk("vga_data", vgaRData, 8'h6E);
      chk("vga_cpu_held", cpuRData, 8'hA5);
      idle(8);

      txn(0, 0, 16'hFFFF, 8'h00, ack, re, wl, dv);
      chk("top_ack_cyc", ack, 3);
      chk("top_data", cpuRData, 8'hC3);
      chk("top_addr", memAddr, 16'hFFFF);
      idle(8);

      // Both requesters held: four CPU grants, then one VGA grant.
      exp_seq = "CCCCVCCCCV";
      for (int i = 0; i < 10; i++) seq[i] = "?";
      cpuReq = 1; cpuWe = 0; cpuAddr = 16'h0100;
      vgaReq = 1; vgaAddr = 16'h0200;
      n = 0;
      for (int c = 0; c < 200 && n < 10; c++) begin
         @(posedge clkMem);
         @(negedge clkMem);
         if (cpuAck) begin seq[n] = "C"; n++; end
         else if (vgaAck) begin seq[n] = "V"; n++; end
      end
      cpuReq = 0; vgaReq = 0;
      for (int i = 0; i < 10; i++)
         chk($sformatf("starve_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
      idle(8);

      cpuReq = 1; cpuWe = 1; cpuAddr = 16'h0042; cpuWData = 8'h77;
      @(posedge clkMem); @(negedge clkMem);
      chk("mid_setup_wen", memWeN, 1);
      chk("mid_setup_data", memData, 8'h77);
      @(posedge clkMem); @(negedge clkMem);
      chk("mid_pulse_wen", memWeN, 0);
      sysRst = 1'b1;
      cpuReq = 1'b0;
      #1;
      chk("mid_rst_wen", memWeN, 1);
      chk("mid_rst_data_z", 32'(memData === 8'hzz), 1);
      chk("mid_rst_busy", busy, 0);
      @(negedge clkMem);
      sysRst = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clkMem);
         if (cpuAck || busy) seen++;
      end
      chk("mid_no_ack_idle", seen, 0);

`ifdef VGA_PREFETCH_EN
      txn(1, 0, 16'h2000, 8'h00, ack, re, wl, dv);
      chk("pf_first_ren", re, 2);
      chk("pf_first_data", vgaRData, 8'h11);
      idle(8);
      txn(1, 0, 16'h2001, 8'h00, ack, re, wl, dv);
      chk("pf_hit_ack_cyc", ack, 1);
      chk("pf_hit_ren", re, 0);
      chk("pf_hit_data", vgaRData, 8'h22);
      idle(8);
      txn(1, 0, 16'h2000, 8'h00, ack, re, wl, dv);
      chk("pf_again_ren", re, 2);
      idle(8);
      txn(0, 1, 16'h2001, 8'h5A, ack, re, wl, dv);
      chk("pf_wr_ack_cyc", ack, 4);
      idle(8);
      txn(1, 0, 16'h2001, 8'h00, ack, re, wl, dv);
      chk("pf_inval_ack_cyc", ack, 3);
      chk("pf_inval_ren", re, 2);
      chk("pf_inval_data", vgaRData, 8'h5A);
`else
      txn(1, 0, 16'h2000, 8'h00, ack, re, wl, dv);
      chk("seq_first_data", vgaRData, 8'h11);
      idle(8);
      txn(1, 0, 16'h2001, 8'h00, ack, re, wl, dv);
      chk("seq_second_ack_cyc", ack, 3);
      chk("seq_second_ren", re, 2);
      chk("seq_second_data", vgaRData, 8'h22);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
